// File: rtl/fifo_rd_checker.sv
// Read-side consumer and data checker for the 1:2 asymmetric FIFO test path.
// The write side carries an incrementing H-bit counter; every popped word must
// hold two consecutive counter values (older value in the upper half), and
// consecutive words must continue the sequence. Words and errors are counted
// for LEDs and debug probes.
//
// Handshake: rd_en_o is a request only; the FIFO may ignore it while empty.
// A word is consumed exactly on a cycle with rd_valid_i=1, whatever the FIFO
// read latency, and rd_en_o is never used to qualify data.
module fifo_rd_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 24,
  parameter bit STOP_ON_ERROR = 1'b0
) (
  input  logic                  rd_clk_i,
  input  logic                  sys_rst,
  input  logic                  start_i,
  input  logic                  rst_busy_i,
  input  logic                  fill_trig_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rd_valid_i,
  output logic                  active_o,
  output logic                  error_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic [DATA_WIDTH-1:0] first_err_o,
  output logic [1:0]            dbg_state_o
);

  localparam int H = DATA_WIDTH / 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_FILL = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_HALT      = 2'd3;

  localparam logic [H-1:0]         ONE_H   = 1;
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = 1;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic         seeded;
  logic [H-1:0] expected;

  logic [H-1:0] upper;
  logic [H-1:0] lower;
  logic [H-1:0] upper_inc;
  logic [H-1:0] lower_inc;
  logic         check_en;
  logic         intra_err;
  logic         inter_err;
  logic         word_err;
  logic         halt_req;

  assign upper     = rdata_i[DATA_WIDTH-1:H];
  assign lower     = rdata_i[H-1:0];
  assign upper_inc = upper + ONE_H;
  assign lower_inc = lower + ONE_H;

  // Late words still drain out of the FIFO pipeline after RUN is left, so
  // checking covers every state except IDLE.
  assign check_en  = rd_valid_i && (state != S_IDLE);
  assign intra_err = (lower != upper_inc);
  assign inter_err = seeded && (upper != expected);
  assign word_err  = check_en && (intra_err || inter_err);
  assign halt_req  = STOP_ON_ERROR && word_err;

  assign active_o    = (state == S_RUN);
  assign dbg_state_o = state;

  // Next-state selection; a low start_i always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (!start_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (!rst_busy_i) state_nxt = S_WAIT_FILL;
        S_WAIT_FILL: if (fill_trig_i) state_nxt = S_RUN;
        S_RUN:       if (halt_req)    state_nxt = S_HALT;
        S_HALT:      state_nxt = S_HALT;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge rd_clk_i) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Registered read request; it also drops immediately on stop or halt so no
  // extra read is issued in the cycle the state machine leaves RUN.
  always_ff @(posedge rd_clk_i) begin
    if (sys_rst) rd_en_o <= 1'b0;
    else         rd_en_o <= (state == S_RUN) && start_i && !empty_i &&
                            !rst_busy_i && !halt_req;
  end

  // Sequence tracker: resync to every valid word so one glitch gives one error.
  always_ff @(posedge rd_clk_i) begin
    if (sys_rst) begin
      seeded   <= 1'b0;
      expected <= '0;
    end else begin
      if (check_en) expected <= lower_inc;
      if (!start_i || state == S_IDLE) seeded <= 1'b0;
      else if (check_en)               seeded <= 1'b1;
    end
  end

  // Word/error counters, sticky flag and first-error capture; held across stop.
  always_ff @(posedge rd_clk_i) begin
    if (sys_rst) begin
      word_cnt_o  <= '0;
      err_cnt_o   <= '0;
      error_o     <= 1'b0;
      first_err_o <= '0;
    end else begin
      if (check_en) word_cnt_o <= word_cnt_o + ONE_CNT;
      if (word_err) begin
        if (err_cnt_o != {CNT_WIDTH{1'b1}}) err_cnt_o <= err_cnt_o + ONE_CNT;
        if (!error_o) first_err_o <= rdata_i;
        error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: a default instance and a
// STOP_ON_ERROR=1 / CNT_WIDTH=4 instance driven from one linear sequence.
module tb_fifo_rd_checker;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // ---------------- instance a (defaults) ----------------
  logic          a_rst = 1'b1, a_start = 1'b0, a_busy = 1'b0, a_fill = 1'b0;
  logic          a_empty = 1'b1, a_valid = 1'b0;
  logic [DW-1:0] a_rdata = '0;
  logic          a_rd_en, a_active, a_error;
  logic [23:0]   a_err_cnt, a_word_cnt;
  logic [DW-1:0] a_first_err;
  logic [1:0]    a_state;

  fifo_rd_checker u_a (
    .rd_clk_i(rd_clk), .sys_rst(a_rst), .start_i(a_start), .rst_busy_i(a_busy),
    .fill_trig_i(a_fill), .empty_i(a_empty), .rd_en_o(a_rd_en),
    .rdata_i(a_rdata), .rd_valid_i(a_valid), .active_o(a_active),
    .error_o(a_error), .err_cnt_o(a_err_cnt), .word_cnt_o(a_word_cnt),
    .first_err_o(a_first_err), .dbg_state_o(a_state)
  );

  // ---------------- instance b (halt on error, 4-bit counters) ----------------
  logic          b_rst = 1'b1, b_start = 1'b0, b_busy = 1'b0, b_fill = 1'b0;
  logic          b_empty = 1'b1, b_valid = 1'b0;
  logic [DW-1:0] b_rdata = '0;
  logic          b_rd_en, b_active, b_error;
  logic [3:0]    b_err_cnt, b_word_cnt;
  logic [DW-1:0] b_first_err;
  logic [1:0]    b_state;

  fifo_rd_checker #(.DATA_WIDTH(32), .CNT_WIDTH(4), .STOP_ON_ERROR(1'b1)) u_b (
    .rd_clk_i(rd_clk), .sys_rst(b_rst), .start_i(b_start), .rst_busy_i(b_busy),
    .fill_trig_i(b_fill), .empty_i(b_empty), .rd_en_o(b_rd_en),
    .rdata_i(b_rdata), .rd_valid_i(b_valid), .active_o(b_active),
    .error_o(b_error), .err_cnt_o(b_err_cnt), .word_cnt_o(b_word_cnt),
    .first_err_o(b_first_err), .dbg_state_o(b_state)
  );

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic a_reset();
    a_rst = 1'b1; a_start = 1'b0; a_fill = 1'b0; a_busy = 1'b0;
    a_empty = 1'b1; a_valid = 1'b0; a_rdata = '0;
    tick(); tick();
    a_rst = 1'b0;
  endtask

  // IDLE -> WAIT_FILL -> RUN, then one more cycle for rd_en_o to register.
  task automatic a_go_run();
    a_start = 1'b1; a_fill = 1'b1; a_empty = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic a_push(input logic [DW-1:0] w);
    a_valid = 1'b1; a_rdata = w;
    tick();
  endtask

  task automatic a_gap();
    a_valid = 1'b0;
    tick();
  endtask

  task automatic b_push(input logic [DW-1:0] w);
    b_valid = 1'b1; b_rdata = w;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    a_reset();
    chk("rst_state", a_state, 2'd0);
    chk("rst_rd_en", a_rd_en, 1'b0);
    chk("rst_active", a_active, 1'b0);
    chk("rst_error", a_error, 1'b0);
    chk("rst_err_cnt", a_err_cnt, 24'd0);
    chk("rst_word_cnt", a_word_cnt, 24'd0);
    chk("rst_first_err", a_first_err, 32'd0);

    // Normal stream with RUN-entry latency of rd_en_o
    a_start = 1'b1; a_empty = 1'b0;
    tick();
    chk("norm_wait_fill", a_state, 2'd1);
    a_fill = 1'b1;
    tick();
    chk("norm_run", a_state, 2'd2);
    chk("norm_active", a_active, 1'b1);
    chk("norm_rd_en_lag", a_rd_en, 1'b0);
    tick();
    chk("norm_rd_en_on", a_rd_en, 1'b1);
    a_push(32'h0001_0002);
    chk("norm_cnt1", a_word_cnt, 24'd1);
    a_push(32'h0003_0004);
    a_push(32'h0005_0006);
    a_gap();
    chk("norm_cnt3", a_word_cnt, 24'd3);
    chk("norm_error", a_error, 1'b0);
    chk("norm_err_cnt", a_err_cnt, 24'd0);

    // Intra-word error
    a_reset();
    a_go_run();
    a_push(32'h0001_0002);
    chk("intra_no_err_yet", a_error, 1'b0);
    a_push(32'h0003_0005);
    chk("intra_error", a_error, 1'b1);
    chk("intra_err_cnt", a_err_cnt, 24'd1);
    chk("intra_first_err", a_first_err, 32'h0003_0005);
    a_gap();

    // Inter-word gap with resync
    a_reset();
    a_go_run();
    a_push(32'h0001_0002);
    a_push(32'h0005_0006);
    a_push(32'h0007_0008);
    a_gap();
    chk("gap_err_cnt", a_err_cnt, 24'd1);
    chk("gap_first_err", a_first_err, 32'h0005_0006);
    chk("gap_word_cnt", a_word_cnt, 24'd3);

    // Counter wrap with an empty stall
    a_reset();
    a_go_run();
    a_push(32'hFFFD_FFFE);
    a_valid = 1'b0; a_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap_rd_en_empty", a_rd_en, 1'b0);
    end
    a_empty = 1'b0;
    a_push(32'hFFFF_0000);
    chk("wrap_rd_en_resume", a_rd_en, 1'b1);
    a_push(32'h0001_0002);
    a_gap();
    chk("wrap_error", a_error, 1'b0);
    chk("wrap_word_cnt", a_word_cnt, 24'd3);

    // Stop and restart re-seeds; counters held
    a_start = 1'b0;
    tick();
    chk("stop_rd_en", a_rd_en, 1'b0);
    chk("stop_state", a_state, 2'd0);
    chk("stop_cnt_held", a_word_cnt, 24'd3);
    a_go_run();
    a_push(32'h1000_1001);
    a_gap();
    chk("restart_error", a_error, 1'b0);
    chk("restart_word_cnt", a_word_cnt, 24'd4);

    // rst_busy_i during RUN gates reads without changing state
    a_busy = 1'b1;
    tick();
    chk("busy_rd_en", a_rd_en, 1'b0);
    chk("busy_state", a_state, 2'd2);
    a_busy = 1'b0;
    tick();
    chk("busy_release_rd_en", a_rd_en, 1'b1);

    // Error then reset coinciding with a valid word
    a_push(32'h2000_2005);
    chk("pre_rst_error", a_error, 1'b1);
    a_rst = 1'b1; a_rdata = 32'h1234_5678; a_valid = 1'b1;
    tick();
    a_rst = 1'b0; a_valid = 1'b0;
    chk("midrst_error", a_error, 1'b0);
    chk("midrst_err_cnt", a_err_cnt, 24'd0);
    chk("midrst_word_cnt", a_word_cnt, 24'd0);
    chk("midrst_first_err", a_first_err, 32'd0);
    chk("midrst_rd_en", a_rd_en, 1'b0);
    chk("midrst_state", a_state, 2'd0);
    a_start = 1'b0;

    // STOP_ON_ERROR instance: halt, late words, saturation
    b_rst = 1'b1;
    tick(); tick();
    b_rst = 1'b0;
    b_start = 1'b1; b_fill = 1'b1; b_empty = 1'b0;
    tick(); tick(); tick();
    chk("b_run", b_state, 2'd2);
    chk("b_rd_en", b_rd_en, 1'b1);
    b_push(32'h0001_0002);
    b_push(32'h0003_0005);
    chk("b_halt_state", b_state, 2'd3);
    chk("b_halt_rd_en", b_rd_en, 1'b0);
    chk("b_halt_active", b_active, 1'b0);
    chk("b_err_cnt1", b_err_cnt, 4'd1);
    chk("b_first_err", b_first_err, 32'h0003_0005);
    b_push(32'h0006_0007);
    chk("b_late_err_cnt", b_err_cnt, 4'd1);
    chk("b_late_word_cnt", b_word_cnt, 4'd3);
    for (int i = 0; i < 20; i++) begin
      b_push(32'h0000_0000);
      chk("b_sat_rd_en", b_rd_en, 1'b0);
    end
    b_valid = 1'b0;
    tick();
    chk("b_sat_err_cnt", b_err_cnt, 4'd15);
    chk("b_wrap_word_cnt", b_word_cnt, 4'd7);
    chk("b_sticky", b_error, 1'b1);
    chk("b_still_halt", b_state, 2'd3);
    b_start = 1'b0;
    tick();
    chk("b_leave_halt", b_state, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
